// File: rtl/uart_echo_ctrl.sv
// CoreUART echo sequencer: RX handshake FSM -> byte FIFO -> TX handshake FSM.
// Optional build macro ECHO_UPCASE_EN maps 'a'..'z' to upper case on transmit.
module uart_echo_ctrl #(
   parameter int FIFO_AW     = 4,
   parameter int ACK_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rxrdy,
   input  logic [7:0]         rx_data,
   output logic               oen,
   input  logic               txrdy,
   output logic [7:0]         tx_data,
   output logic               wen,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic               hs_error
);
   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int CW    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0]    TO_LAST  = CW'(ACK_TIMEOUT - 1);
   localparam logic [FIFO_AW:0] FULL_LVL = (FIFO_AW + 1)'(DEPTH);

   typedef enum logic {RX_IDLE, RX_ACK} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_BUSY, TX_DONE} tx_state_t;

   rx_state_t          rx_state_r, rx_state_s;
   tx_state_t          tx_state_r, tx_state_s;
   logic [CW-1:0]      rx_cnt_r, rx_cnt_s, tx_cnt_r, tx_cnt_s;
   logic               rx_armed_r, rx_armed_s;
   logic               oen_r, oen_s, wen_r, wen_s;
   logic [7:0]         tx_data_r, tx_data_s;
   logic [FIFO_AW:0]   level_r, level_s;
   logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
   logic               overflow_r, hs_error_r;
   logic               push_s, pop_s, drop_s, rx_to_s, tx_to_s;
   logic [7:0]         mem [DEPTH];

   function automatic logic [7:0] echo_map(input logic [7:0] b);
`ifdef ECHO_UPCASE_EN
      if (b >= 8'h61 && b <= 8'h7A) begin
         echo_map = b & 8'hDF;
      end else begin
         echo_map = b;
      end
`else
      echo_map = b;
`endif
   endfunction

   // RX handshake: accept a byte, hold oen low until rxrdy drops or timeout
   always_comb begin
      rx_state_s = rx_state_r;
      rx_cnt_s   = rx_cnt_r;
      rx_armed_s = rx_armed_r;
      oen_s      = oen_r;
      push_s     = 1'b0;
      drop_s     = 1'b0;
      rx_to_s    = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            if (rxrdy && rx_armed_r) begin
               rx_state_s = RX_ACK;
               rx_cnt_s   = '0;
               oen_s      = 1'b0;
               if (level_r < FULL_LVL) begin
                  push_s = 1'b1;
               end else begin
                  drop_s = 1'b1;
               end
            end else begin
               rx_armed_s = rx_armed_r | ~rxrdy;
            end
         end
         RX_ACK: begin
            if (!rxrdy) begin
               rx_state_s = RX_IDLE;
               oen_s      = 1'b1;
               rx_armed_s = 1'b1;
            end else if (rx_cnt_r == TO_LAST) begin
               // after a timeout the same byte must not be re-read
               rx_state_s = RX_IDLE;
               oen_s      = 1'b1;
               rx_armed_s = 1'b0;
               rx_to_s    = 1'b1;
            end else begin
               rx_cnt_s = rx_cnt_r + CW'(1);
            end
         end
         default: begin
            rx_state_s = RX_IDLE;
            oen_s      = 1'b1;
         end
      endcase
   end

   // TX handshake: pop, one-cycle wen strobe, then follow txrdy low/high
   always_comb begin
      tx_state_s = tx_state_r;
      tx_cnt_s   = tx_cnt_r;
      tx_data_s  = tx_data_r;
      wen_s      = 1'b1;
      pop_s      = 1'b0;
      tx_to_s    = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            if (level_r != '0 && txrdy) begin
               pop_s      = 1'b1;
               tx_data_s  = echo_map(mem[rd_ptr_r]);
               wen_s      = 1'b0;
               tx_state_s = TX_STROBE;
            end else begin
               tx_state_s = TX_IDLE;
            end
         end
         TX_STROBE: begin
            tx_state_s = TX_BUSY;
            tx_cnt_s   = '0;
         end
         TX_BUSY: begin
            if (!txrdy) begin
               tx_state_s = TX_DONE;
            end else if (tx_cnt_r == TO_LAST) begin
               tx_state_s = TX_IDLE;
               tx_to_s    = 1'b1;
            end else begin
               tx_cnt_s = tx_cnt_r + CW'(1);
            end
         end
         TX_DONE: begin
            if (txrdy) begin
               tx_state_s = TX_IDLE;
            end else begin
               tx_state_s = TX_DONE;
            end
         end
         default: begin
            tx_state_s = TX_IDLE;
         end
      endcase
   end

   // FIFO occupancy; a same-cycle push and pop cancel
   always_comb begin
      case ({push_s, pop_s})
         2'b10:   level_s = level_r + (FIFO_AW + 1)'(1);
         2'b01:   level_s = level_r - (FIFO_AW + 1)'(1);
         default: level_s = level_r;
      endcase
   end

   // State, pointer and registered-output update
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_r <= RX_IDLE;
         tx_state_r <= TX_IDLE;
         rx_cnt_r   <= '0;
         tx_cnt_r   <= '0;
         rx_armed_r <= 1'b1;
         oen_r      <= 1'b1;
         wen_r      <= 1'b1;
         tx_data_r  <= 8'h00;
         level_r    <= '0;
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         overflow_r <= 1'b0;
         hs_error_r <= 1'b0;
      end else begin
         rx_state_r <= rx_state_s;
         tx_state_r <= tx_state_s;
         rx_cnt_r   <= rx_cnt_s;
         tx_cnt_r   <= tx_cnt_s;
         rx_armed_r <= rx_armed_s;
         oen_r      <= oen_s;
         wen_r      <= wen_s;
         tx_data_r  <= tx_data_s;
         level_r    <= level_s;
         wr_ptr_r   <= wr_ptr_r + FIFO_AW'(push_s);
         rd_ptr_r   <= rd_ptr_r + FIFO_AW'(pop_s);
         overflow_r <= overflow_r | drop_s;
         hs_error_r <= hs_error_r | rx_to_s | tx_to_s;
      end
   end

   // FIFO storage holds raw received bytes
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem[wr_ptr_r] <= rx_data;
      end
   end

   assign oen        = oen_r;
   assign wen        = wen_r;
   assign tx_data    = tx_data_r;
   assign fifo_level = level_r;
   assign overflow   = overflow_r;
   assign hs_error   = hs_error_r;
endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Scoreboard bench for uart_echo_ctrl: randomized UART byte traffic, queue-based
// expected echo stream, directed reset/overflow/timeout/upcase scenarios.
module tb_uart_echo_ctrl;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          rxrdy;
   logic [7:0]    rx_data;
   logic          oen;
   logic          txrdy;
   logic [7:0]    tx_data;
   logic          wen;
   logic [AW:0]   fifo_level;
   logic          overflow;
   logic          hs_error;

   int total = 0;
   int bad   = 0;
   int tx_mode = 0;            // 0 responsive UART, 1 txrdy held 0, 2 txrdy held 1
   logic [7:0] exp_q[$];

   uart_echo_ctrl #(.FIFO_AW(AW), .ACK_TIMEOUT(64)) dut (
      .clk(clk), .rst(rst), .rxrdy(rxrdy), .rx_data(rx_data), .oen(oen),
      .txrdy(txrdy), .tx_data(tx_data), .wen(wen), .fifo_level(fifo_level),
      .overflow(overflow), .hs_error(hs_error)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] model(input logic [7:0] b);
`ifdef ECHO_UPCASE_EN
      if (b >= 8'h61 && b <= 8'h7A) return b - 8'd32;
`endif
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reads one byte through the rxrdy/oen handshake
   task automatic send_byte(input logic [7:0] b, input bit accepted);
      int n;
      @(negedge clk);
      rxrdy = 1'b1;
      rx_data = b;
      if (accepted) exp_q.push_back(model(b));
      @(negedge clk);
      n = 1;
      while (oen !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      check("rx_ack_low", {31'd0, oen}, 32'd0);
      rxrdy = 1'b0;
      rx_data = 8'($urandom);
      n = 0;
      while (oen !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      check("rx_ack_release", {31'd0, oen}, 32'd1);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
      check("drain_remaining", exp_q.size(), 32'd0);
   endtask

   task automatic check_reset_state();
      check("rst_oen", {31'd0, oen}, 32'd1);
      check("rst_wen", {31'd0, wen}, 32'd1);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_level", {27'd0, fifo_level}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_hs_error", {31'd0, hs_error}, 32'd0);
   endtask

   // UART transmitter model: drops txrdy for a few cycles after each wen strobe
   initial begin
      int busy;
      busy = 0;
      txrdy = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_mode == 1) begin
            txrdy = 1'b0; busy = 0;
         end else if (tx_mode == 2) begin
            txrdy = 1'b1; busy = 0;
         end else if (busy > 0) begin
            busy--;
            txrdy = (busy == 0);
         end else if (wen === 1'b0) begin
            txrdy = 1'b0;
            busy = $urandom_range(2, 4);
         end else begin
            txrdy = 1'b1;
         end
      end
   end

   // Monitor: every wen strobe pops the scoreboard
   initial begin
      logic prev_wen;
      prev_wen = 1'b1;
      forever begin
         @(negedge clk);
         if (rst !== 1'b0) begin
            prev_wen = 1'b1;
         end else begin
            if (wen === 1'b0) begin
               check("wen_one_cycle", {31'd0, prev_wen}, 32'd1);
               if (exp_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_tx: got %0h expected none at %0t", tx_data, $time);
               end else begin
                  check("echo_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
               end
            end
            prev_wen = wen;
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      rst = 1'b1;
      rxrdy = 1'b0;
      rx_data = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_state();
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single byte with exact latency
      rxrdy = 1'b1;
      rx_data = 8'h8F;
      exp_q.push_back(model(8'h8F));
      @(negedge clk);
      check("lat_oen", {31'd0, oen}, 32'd0);
      check("lat_wen_early", {31'd0, wen}, 32'd1);
      @(negedge clk);
      check("lat_wen", {31'd0, wen}, 32'd0);
      check("lat_tx_data", {24'd0, tx_data}, {24'd0, model(8'h8F)});
      check("lat_oen_held", {31'd0, oen}, 32'd0);
      rxrdy = 1'b0;
      @(negedge clk);
      check("lat_oen_release", {31'd0, oen}, 32'd1);
      wait_drain(50);
      check("single_overflow", {31'd0, overflow}, 32'd0);

      // random traffic
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) b = 8'($urandom_range(8'h61, 8'h7A));
         else b = 8'($urandom);
         send_byte(b, 1'b1);
         repeat ($urandom_range(6, 14)) @(negedge clk);
      end
      wait_drain(300);
      check("rand_overflow", {31'd0, overflow}, 32'd0);
      check("rand_level", {27'd0, fifo_level}, 32'd0);

      // case-mapping boundaries
      send_byte(8'h61, 1'b1);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h7B, 1'b1);
      send_byte(8'h60, 1'b1);
      send_byte(8'h7A, 1'b1);
      wait_drain(200);

      // fill past capacity with TX blocked
      tx_mode = 1;
      repeat (8) @(negedge clk);
      for (int i = 0; i <= DEPTH; i++) send_byte(8'($urandom), i < DEPTH);
      check("full_level", {27'd0, fifo_level}, DEPTH);
      check("full_overflow", {31'd0, overflow}, 32'd1);
      tx_mode = 0;
      wait_drain(600);
      check("full_drained_level", {27'd0, fifo_level}, 32'd0);

      // rxrdy stuck high
      @(negedge clk);
      rxrdy = 1'b1;
      rx_data = 8'h3C;
      exp_q.push_back(model(8'h3C));
      for (int k = 1; k <= 85; k++) begin
         @(negedge clk);
         if (k == 64) begin
            check("rxto_oen_before", {31'd0, oen}, 32'd0);
            check("rxto_err_before", {31'd0, hs_error}, 32'd0);
         end
         if (k == 65) begin
            check("rxto_oen_after", {31'd0, oen}, 32'd1);
            check("rxto_err_after", {31'd0, hs_error}, 32'd1);
         end
      end
      check("rxto_no_reread", {31'd0, oen}, 32'd1);
      check("rxto_level", {27'd0, fifo_level}, 32'd0);
      rxrdy = 1'b0;
      wait_drain(50);

      // reset in the middle of an RX handshake
      tx_mode = 1;
      repeat (3) @(negedge clk);
      rxrdy = 1'b1;
      rx_data = 8'hA5;
      repeat (3) @(negedge clk);
      check("mid_oen", {31'd0, oen}, 32'd0);
      check("mid_level", {27'd0, fifo_level}, 32'd1);
      rst = 1'b1;
      rxrdy = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state();
      rst = 1'b0;
      tx_mode = 0;
      repeat (20) @(negedge clk);
      check("post_rst_level", {27'd0, fifo_level}, 32'd0);

      // txrdy stuck high after strobe
      tx_mode = 2;
      repeat (2) @(negedge clk);
      send_byte(8'h42, 1'b1);
      wait_drain(20);
      check("txto_err_before", {31'd0, hs_error}, 32'd0);
      repeat (75) @(negedge clk);
      check("txto_err_after", {31'd0, hs_error}, 32'd1);
      send_byte(8'h17, 1'b1);
      wait_drain(20);
      tx_mode = 0;
      repeat (10) @(negedge clk);

      check("final_queue", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
